otter_dbus_decoder: RTL and testbench

OTTER_DBUS_DECODER -- requirements
Module: otter_dbus_decoder

---
 rtl/otter_dbus_decoder.sv | 167 ++++++++++++++++
 tb/tb_otter_dbus_decoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/otter_dbus_decoder.sv
// rtl/otter_dbus_decoder.sv - address decoder and handshake sequencer for the OTTER data bus
module otter_dbus_decoder #(
    parameter int                       N_SLAVES       = 4,
    parameter logic [32*N_SLAVES-1:0]   SLAVE_BASE     = {32'h1100_0200, 32'h1100_0100, 32'h1100_0000, 32'h8000_0000},
    parameter logic [32*N_SLAVES-1:0]   SLAVE_MASK     = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'h8000_0000},
    parameter int                       TIMEOUT_CYCLES = 16,
    parameter logic [31:0]              ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_m_re,
    input  logic                        i_m_we,
    input  logic [3:0]                  i_m_sel,
    input  logic [31:0]                 i_m_addr,
    input  logic [31:0]                 i_m_w_data,
    output logic [31:0]                 o_m_r_data,
    output logic                        o_m_ack,
    output logic                        o_m_err,
    output logic [N_SLAVES-1:0]         o_s_re,
    output logic [N_SLAVES-1:0]         o_s_we,
    output logic [3:0]                  o_s_sel,
    output logic [31:0]                 o_s_addr,
    output logic [31:0]                 o_s_w_data,
    input  logic [32*N_SLAVES-1:0]      i_s_r_data,
    input  logic [N_SLAVES-1:0]         i_s_ack
);

    localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            req;
    logic            hit;
    logic [IW-1:0]   hit_idx;
    logic [IW-1:0]   s_idx;
    logic            s_write;
    logic [31:0]     busy_cnt;
    logic            sel_ack;
    logic [31:0]     sel_r_data;
    logic            timeout_hit;
    logic [N_SLAVES-1:0] s_onehot;

    assign req = i_m_re | i_m_we;

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((i_m_addr & SLAVE_MASK[32*i +: 32]) ==
                (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        sel_ack    = 1'b0;
        sel_r_data = '0;
        s_onehot   = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (s_idx == IW'(i)) begin
                sel_ack     = i_s_ack[i];
                sel_r_data  = i_s_r_data[32*i +: 32];
                s_onehot[i] = 1'b1;
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (busy_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = hit ? BUSY : RESP;
                end
            end
            BUSY: begin
                if (sel_ack || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_s_re  = '0;
        o_s_we  = '0;
        o_m_ack = 1'b0;
        if (state == BUSY) begin
            if (s_write) begin
                o_s_we = s_onehot;
            end else begin
                o_s_re = s_onehot;
            end
        end
        if (state == RESP) begin
            o_m_ack = 1'b1;
        end
    end

    // Ack is tested before timeout so a same-cycle ack always wins.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_s_addr   <= '0;
            o_s_sel    <= '0;
            o_s_w_data <= '0;
            o_m_r_data <= '0;
            o_m_err    <= 1'b0;
            s_idx      <= '0;
            s_write    <= 1'b0;
            busy_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (hit) begin
                            o_s_addr   <= i_m_addr;
                            o_s_sel    <= i_m_sel;
                            o_s_w_data <= i_m_w_data;
                            s_idx      <= hit_idx;
                            s_write    <= i_m_we;
                            busy_cnt   <= '0;
                        end else begin
                            o_m_err    <= 1'b1;
                            o_m_r_data <= ERR_DATA;
                        end
                    end
                end
                BUSY: begin
                    if (sel_ack) begin
                        o_m_err    <= 1'b0;
                        o_m_r_data <= s_write ? 32'h0 : sel_r_data;
                    end else if (timeout_hit) begin
                        o_m_err    <= 1'b1;
                        o_m_r_data <= ERR_DATA;
                    end else begin
                        busy_cnt   <= busy_cnt + 32'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_otter_dbus_decoder.sv
// tb/tb_otter_dbus_decoder.sv - directed bench with a cycle-expectation queue model
module tb_otter_dbus_decoder;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_m_re, i_m_we;
    logic [3:0]   i_m_sel;
    logic [31:0]  i_m_addr, i_m_w_data;
    logic [31:0]  o_m_r_data;
    logic         o_m_ack, o_m_err;
    logic [3:0]   o_s_re, o_s_we;
    logic [3:0]   o_s_sel;
    logic [31:0]  o_s_addr, o_s_w_data;
    logic [127:0] i_s_r_data;
    logic [3:0]   i_s_ack;

    always #5 clk = ~clk;

    otter_dbus_decoder dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_m_re     (i_m_re),
        .i_m_we     (i_m_we),
        .i_m_sel    (i_m_sel),
        .i_m_addr   (i_m_addr),
        .i_m_w_data (i_m_w_data),
        .o_m_r_data (o_m_r_data),
        .o_m_ack    (o_m_ack),
        .o_m_err    (o_m_err),
        .o_s_re     (o_s_re),
        .o_s_we     (o_s_we),
        .o_s_sel    (o_s_sel),
        .o_s_addr   (o_s_addr),
        .o_s_w_data (o_s_w_data),
        .i_s_r_data (i_s_r_data),
        .i_s_ack    (i_s_ack)
    );

    typedef struct {
        logic [3:0]  re;
        logic [3:0]  we;
        logic        ack;
        logic        err;
        logic        clr;
        logic        bus;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic        started = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e.re = '0; e.we = '0; e.ack = 1'b0; e.err = 1'b0; e.clr = 1'b0; e.bus = 1'b0;
        e.rdata = '0; e.addr = '0; e.wdata = '0; e.sel = '0;
        return e;
    endfunction

    // Address map as a lookup table: first matching slot wins.
    function automatic int decode(input logic [31:0] a);
        logic [31:0] base [4] = '{32'h8000_0000, 32'h1100_0000, 32'h1100_0100, 32'h1100_0200};
        logic [31:0] mask [4] = '{32'h8000_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};
        for (int i = 0; i < 4; i++) begin
            if ((a & mask[i]) == (base[i] & mask[i])) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = idle_e();
            if (e.clr) exp_rdata = 32'h0;
            if (e.ack) exp_rdata = e.rdata;
            chk("s_re", 32'(o_s_re), 32'(e.re));
            chk("s_we", 32'(o_s_we), 32'(e.we));
            chk("m_ack", 32'(o_m_ack), 32'(e.ack));
            if (e.ack || e.clr) chk("m_err", 32'(o_m_err), 32'(e.err));
            chk("m_r_data", o_m_r_data, exp_rdata);
            if (e.bus) begin
                chk("s_addr", o_s_addr, e.addr);
                chk("s_sel", 32'(o_s_sel), 32'(e.sel));
                chk("s_w_data", o_s_w_data, e.wdata);
            end
            if (e.clr) begin
                chk("rst_s_addr", o_s_addr, 32'h0);
                chk("rst_s_sel", 32'(o_s_sel), 32'h0);
                chk("rst_s_w_data", o_s_w_data, 32'h0);
            end
        end
    end

    // ack_wait: BUSY cycles without ack before the ack cycle; negative means never.
    task automatic txn(input logic re, input logic we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int ack_wait, input logic [31:0] sdata, input int stray);
        int   idx;
        int   nb;
        logic timed_out;
        exp_t e;
        idx       = decode(addr);
        timed_out = (ack_wait < 0) || (ack_wait >= 16);
        nb        = (idx < 0) ? 0 : (timed_out ? 16 : ack_wait + 1);
        @(posedge clk); #1;
        i_m_re = re; i_m_we = we; i_m_sel = sel; i_m_addr = addr; i_m_w_data = wdata;
        if (idx >= 0) i_s_r_data[32*idx +: 32] = sdata;
        q.push_back(idle_e());
        for (int c = 1; c <= nb; c++) begin
            e = idle_e();
            if (we) e.we[idx] = 1'b1;
            else    e.re[idx] = 1'b1;
            e.bus = 1'b1; e.addr = addr; e.wdata = wdata; e.sel = sel;
            q.push_back(e);
        end
        e = idle_e();
        e.ack   = 1'b1;
        e.err   = (idx < 0) || timed_out;
        e.rdata = e.err ? 32'hDEAD_BEEF : (we ? 32'h0 : sdata);
        q.push_back(e);
        for (int c = 1; c <= nb; c++) begin
            @(posedge clk); #1;
            i_s_ack = '0;
            if (c == ack_wait + 1) i_s_ack[idx] = 1'b1;
            if (stray >= 0 && c == 2) i_s_ack[stray] = 1'b1;
        end
        @(posedge clk); #1;
        i_s_ack = '0;
        @(posedge clk); #1;
        i_m_re = 1'b0; i_m_we = 1'b0;
    endtask

    initial begin
        exp_t e;
        i_rst = 1'b1; i_m_re = 1'b0; i_m_we = 1'b0; i_m_sel = '0;
        i_m_addr = '0; i_m_w_data = '0; i_s_r_data = '0; i_s_ack = '0;
        @(posedge clk); #1;
        e = idle_e(); e.clr = 1'b1;
        q.push_back(e);
        started = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;

        txn(1'b1, 1'b0, 4'hF, 32'h8000_0010, 32'h0, 0, 32'h1234_5678, -1);
        chk("pin_read_data", o_m_r_data, 32'h1234_5678);

        txn(1'b0, 1'b1, 4'b0011, 32'h1100_0104, 32'hA5A5_A5A5, 3, 32'h9999_9999, -1);
        chk("pin_write_data", o_m_r_data, 32'h0);

        txn(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 0, 32'h0, -1);
        chk("pin_decode_err", o_m_r_data, 32'hDEAD_BEEF);
        chk("pin_decode_err_flag", 32'(o_m_err), 32'h1);

        txn(1'b1, 1'b0, 4'hF, 32'h1100_0000, 32'h0, -1, 32'h5555_0000, -1);
        chk("pin_timeout_data", o_m_r_data, 32'hDEAD_BEEF);

        txn(1'b1, 1'b0, 4'hF, 32'h1100_0004, 32'h0, 3, 32'hCAFE_0001, 3);
        chk("pin_stray_ignored", o_m_r_data, 32'hCAFE_0001);

        // Reset lands while the slave1 read is in its second BUSY cycle.
        @(posedge clk); #1;
        i_m_re = 1'b1; i_m_addr = 32'h1100_0010; i_m_sel = 4'hF; i_m_w_data = 32'h0;
        q.push_back(idle_e());
        for (int c = 0; c < 2; c++) begin
            e = idle_e();
            e.re[1] = 1'b1; e.bus = 1'b1; e.addr = 32'h1100_0010; e.sel = 4'hF; e.wdata = 32'h0;
            q.push_back(e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0; i_m_re = 1'b0;
        e = idle_e(); e.clr = 1'b1;
        q.push_back(e);
        @(posedge clk); #1;

        txn(1'b1, 1'b1, 4'hF, 32'h8000_0020, 32'h1357_9BDF, 0, 32'h7777_7777, -1);
        chk("pin_re_we_write", o_m_r_data, 32'h0);

        txn(1'b1, 1'b0, 4'hF, 32'h1100_0208, 32'h0, 15, 32'hABCD_0003, -1);
        chk("pin_ack_at_timeout", o_m_r_data, 32'hABCD_0003);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
